regfile_bypass: RTL and testbench
=================================

# regfile_bypass

Parametrised register file for the pipelined MIPS core, generalising the fixed 32×32, two-read-port register bank. It adds a configurable read-port count, same-cycle write-to-read bypass, a hardwired zero register, index-valued reset contents, and a handshaked serial dump port. The bench or debug logic uses the dump port to stream out the architectural state after a program runs. It sits in the ID stage: the WB stage writes it and the ID stage reads it.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2^ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- BYPASS, 1, 1 = a write is visible on a matching read port in the same cycle
- INIT_INDEX, 1, 1 = register i resets to i (zero-extended or truncated to DATA_W); 0 = all registers reset to 0
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  ADDR_W  write index
- wdata  in  DATA_W  write data
- raddr  in  NUM_RD*ADDR_W  read indices; port k occupies bits [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
- dump_start  in  1  request a full-state dump
- dump_busy  out  1  dump in progress
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer accepts the beat
- dump_addr  out  ADDR_W  index of the current beat
- dump_data  out  DATA_W  contents of register dump_addr
- dump_done  out  1  one-cycle pulse after the last beat

## Operation
- Write: on a rising edge with we=1 and waddr≠0, reg[waddr] ← wdata. Writes to index 0 are discarded.
- Read is combinational per port:
  - raddr=0 → 0.
  - BYPASS=1, we=1, waddr=raddr≠0 → wdata.
  - Otherwise → reg[raddr].
- Ports are independent. All ports may address the same register.
- Reset (rst=0): registers take their INIT_INDEX values, with reg[0]=0 in every case. The dump FSM goes to IDLE. dump_busy, dump_valid, dump_done, dump_addr and dump_data are all 0.
- Dump FSM has three states: IDLE, SEND and DONE.
  - IDLE: on dump_start=1, move to SEND with idx=0.
  - SEND: dump_valid=1, dump_addr=idx, dump_data=reg[idx].
    - dump_data shows stored contents, unbypassed. A write landing in the same cycle appears in the next beat only if that beat's index matches.
    - On dump_valid & dump_ready: if idx=2^ADDR_W−1, go to DONE; otherwise idx ← idx+1.
    - With dump_ready=0, idx, dump_addr and dump_valid hold. dump_data tracks live register contents.
  - DONE: dump_done=1 for one cycle, then return to IDLE.
- dump_busy=1 in SEND and DONE.
- dump_start is ignored in SEND and DONE; there is no queueing.
- Writes and reads are allowed in every state. Dumping never stalls the pipeline.
- idx is ADDR_W wide. Completion is detected explicitly, so there is no wrap-around into a second pass.
- Outside SEND: dump_valid=0, and dump_addr and dump_data are 0.

## Timing
- Read latency: 0 cycles (combinational).
- Write visibility: from the next cycle through storage; in the same cycle when BYPASS=1.
- BYPASS=0: same-cycle read of a register being written returns the old value.
- Dump latency:
  - dump_start sampled at edge N → first beat valid in cycle N+1.
  - With dump_ready held high, 2^ADDR_W beats occur in consecutive cycles, and dump_done is high in the cycle after the final handshake.
  - The FSM is back in IDLE 2^ADDR_W+2 cycles after start.
  - A new dump_start is accepted in the cycle after dump_done.
- Reset mid-dump: the dump aborts immediately and asynchronously, with all dump outputs 0. After reset release, the FSM needs a fresh dump_start.
- Reset mid-write: register contents are the reset values; the write is lost.

## Test plan
- Reset values:
  - Stimulus: default params; assert rst=0 for 2 cycles, release; drive raddr port0=3, port1=31.
  - Required response: rdata 3 and 31. Port0=0 reads 0. All dump outputs 0.
- Write and zero register:
  - Stimulus: write 0xDEADBEEF to r0, then 0x5 to r3; next cycle read port0=0, port1=3.
  - Required response: 0x0 and 0x5.
- Bypass:
  - Stimulus: BYPASS=1, same cycle we=1, waddr=6, wdata=0xA5, raddr port0=6.
  - Required response: rdata=0xA5 that cycle.
  - Variant: rebuild with BYPASS=0; the same stimulus returns 6, then 0xA5 next cycle.
- Multi-port:
  - Stimulus: NUM_RD=3, ports read 1, 1 and 31 simultaneously.
  - Required response: 1, 1, 31.
- Dump with backpressure:
  - Stimulus: write r4=0x44; pulse dump_start; hold dump_ready=0 for 3 cycles at idx 2, otherwise 1.
  - Required response: 32 beats with addr 0..31 and data i, except beat 4 = 0x44. Beat 2 holds for 3 cycles. dump_done pulses once. A dump_start pulsed mid-dump is ignored.
- Reset mid-dump:
  - Stimulus: assert rst=0 at beat 10.
  - Required response: dump_busy, dump_valid and dump_done drop immediately. After release, no beats occur until a new dump_start; the next dump begins at addr 0.

Source files
------------

// File: rtl/regfile_bypass.sv
// Parametrised register file with a hardwired zero register, optional
// same-cycle write-to-read bypass, index-valued reset contents and a
// handshaked serial dump port for streaming out architectural state.
//
// Dump FSM states:
//   state  | meaning
//   S_IDLE | waiting for dump_start; dump outputs held at 0
//   S_SEND | presenting beat idx; advances on dump_valid & dump_ready
//   S_DONE | one-cycle dump_done pulse, then back to S_IDLE
module regfile_bypass #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  input  logic                       dump_start,
  output logic                       dump_busy,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic [ADDR_W-1:0]          dump_addr,
  output logic [DATA_W-1:0]          dump_data,
  output logic                       dump_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [DATA_W-1:0] regs [DEPTH];
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;

  // Storage: reset loads index values (r0 always 0); writes to r0 are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= (INIT_INDEX != 0 && i != 0) ? DATA_W'(i) : '0;
      end
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // Combinational read ports: zero register first, then bypass, then storage.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (raddr[k*ADDR_W +: ADDR_W] == '0) begin
        rdata[k*DATA_W +: DATA_W] = '0;
      end else if (BYPASS != 0 && we && waddr == raddr[k*ADDR_W +: ADDR_W]) begin
        rdata[k*DATA_W +: DATA_W] = wdata;
      end else begin
        rdata[k*DATA_W +: DATA_W] = regs[raddr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  // Dump FSM state and beat index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Dump FSM next state and outputs; dump_data shows stored (unbypassed) contents.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    dump_busy  = 1'b0;
    dump_valid = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    dump_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (dump_start) begin
          state_nxt = S_SEND;
          idx_nxt   = '0;
        end
      end
      S_SEND: begin
        dump_busy  = 1'b1;
        dump_valid = 1'b1;
        dump_addr  = idx;
        dump_data  = regs[idx];
        if (dump_ready) begin
          if (idx == '1) begin
            state_nxt = S_DONE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        dump_busy = 1'b1;
        dump_done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: a 3-port bypassing instance and a 1-port
// non-bypassing instance share stimulus and are compared against an
// array model of the architectural registers.
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  ra0, ra1, ra2;
  logic [95:0] rdata;
  logic [31:0] rdata_nb;
  logic        dump_start, dump_ready;
  logic        dump_busy, dump_valid, dump_done;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        nb_busy, nb_valid, nb_done;
  logic [4:0]  nb_addr;
  logic [31:0] nb_data;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] model [32];

  always #5 clk = ~clk;

  regfile_bypass #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .BYPASS(1), .INIT_INDEX(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr({ra2, ra1, ra0}), .rdata(rdata),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done));

  regfile_bypass #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .BYPASS(0), .INIT_INDEX(1)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(ra0), .rdata(rdata_nb),
    .dump_start(1'b0), .dump_busy(nb_busy), .dump_valid(nb_valid),
    .dump_ready(1'b1), .dump_addr(nb_addr), .dump_data(nb_data),
    .dump_done(nb_done));

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra0, ra1, ra2;
    logic [31:0] e0, e1, e2, enb;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'(i);
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (ra == 5'd0) return 32'd0;
    if (byp && we && waddr == ra) return wdata;
    return model[ra];
  endfunction

  // Advance one clock; the model takes the write at the edge. Ends on a negedge.
  task automatic commit();
    @(posedge clk);
    if (we && waddr != 5'd0) model[waddr] = wdata;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0;
    dump_start = 1'b0; dump_ready = 1'b1;
  endtask

  initial begin
    int exp_idx, beats, stalls, hold2;

    rst = 1'b1;
    idle_inputs();
    ra0 = 5'd3; ra1 = 5'd31; ra2 = 5'd0;

    tbl[0] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0, 5'd3, 5'd31, 32'd0,        32'd3,  32'd31, 32'd0};
    tbl[1] = '{1'b1, 5'd3,  32'h5,        5'd0, 5'd3, 5'd1,  32'd0,        32'h5,  32'd1,  32'd0};
    tbl[2] = '{1'b1, 5'd6,  32'hA5,       5'd6, 5'd1, 5'd31, 32'hA5,       32'd1,  32'd31, 32'd6};
    tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd6, 5'd3, 5'd0,  32'hA5,       32'h5,  32'd0,  32'hA5};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd1, 5'd1, 5'd31, 32'd1,        32'd1,  32'd31, 32'd1};
    tbl[5] = '{1'b1, 5'd1,  32'h77,       5'd1, 5'd1, 5'd0,  32'h77,       32'h77, 32'd0,  32'd1};
    tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd1, 5'd2, 5'd0,  32'h77,       32'd2,  32'd0,  32'h77};

    // Reset values, checked while reset is held and after release.
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_rd_p0", rdata[31:0], 32'd3);
    chk("rst_rd_p1", rdata[63:32], 32'd31);
    chk("rst_rd_p2_zero", rdata[95:64], 32'd0);
    chk("rst_dump_busy", 32'(dump_busy), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid), 32'd0);
    chk("rst_dump_done", 32'(dump_done), 32'd0);
    chk("rst_dump_addr", 32'(dump_addr), 32'd0);
    chk("rst_dump_data", dump_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_rd_p1", rdata[63:32], 32'd31);

    // Directed vectors.
    for (int v = 0; v < 7; v++) begin
      we = tbl[v].we; waddr = tbl[v].waddr; wdata = tbl[v].wdata;
      ra0 = tbl[v].ra0; ra1 = tbl[v].ra1; ra2 = tbl[v].ra2;
      #1;
      chk($sformatf("vec%0d_p0", v), rdata[31:0], tbl[v].e0);
      chk($sformatf("vec%0d_p1", v), rdata[63:32], tbl[v].e1);
      chk($sformatf("vec%0d_p2", v), rdata[95:64], tbl[v].e2);
      chk($sformatf("vec%0d_nb", v), rdata_nb, tbl[v].enb);
      commit();
    end

    // Randomised reads and writes against the model.
    for (int n = 0; n < 400; n++) begin
      we    = 1'($urandom_range(0, 1));
      waddr = 5'($urandom);
      wdata = $urandom;
      ra0 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
      ra1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? 5'd0  : 5'($urandom);
      #1;
      chk("rnd_p0", rdata[31:0],   exp_rd(ra0, 1'b1));
      chk("rnd_p1", rdata[63:32],  exp_rd(ra1, 1'b1));
      chk("rnd_p2", rdata[95:64],  exp_rd(ra2, 1'b1));
      chk("rnd_nb", rdata_nb,      exp_rd(ra0, 1'b0));
      commit();
    end
    idle_inputs();

    // Dump with backpressure at beat 2 and an ignored mid-dump start.
    do_reset();
    we = 1'b1; waddr = 5'd4; wdata = 32'h44;
    commit();
    idle_inputs();
    dump_start = 1'b1;
    commit();
    dump_start = 1'b0;
    exp_idx = 0; beats = 0; stalls = 0; hold2 = 0;
    for (int cyc = 0; cyc < 100 && beats < 32; cyc++) begin
      dump_ready = (exp_idx == 2 && stalls < 3) ? 1'b0 : 1'b1;
      dump_start = (exp_idx == 10);
      #1;
      chk("dump_valid", 32'(dump_valid), 32'd1);
      chk("dump_busy", 32'(dump_busy), 32'd1);
      chk("dump_addr", 32'(dump_addr), 32'(exp_idx));
      chk("dump_data", dump_data, model[exp_idx]);
      if (exp_idx == 4) chk("dump_beat4", dump_data, 32'h44);
      if (exp_idx == 2) hold2++;
      @(posedge clk);
      if (dump_ready) begin
        beats++;
        exp_idx++;
      end else begin
        stalls++;
      end
      @(negedge clk);
    end
    chk("dump_beats", 32'(beats), 32'd32);
    chk("dump_hold2", 32'(hold2), 32'd4);
    dump_ready = 1'b1; dump_start = 1'b0;
    #1;
    chk("done_pulse", 32'(dump_done), 32'd1);
    chk("done_busy", 32'(dump_busy), 32'd1);
    chk("done_valid", 32'(dump_valid), 32'd0);
    chk("done_addr", 32'(dump_addr), 32'd0);
    chk("done_data", dump_data, 32'd0);
    commit();
    #1;
    chk("after_done", 32'(dump_done), 32'd0);
    chk("after_busy", 32'(dump_busy), 32'd0);
    commit();
    #1;
    chk("no_second_pass", 32'(dump_valid), 32'd0);

    // Reset in the middle of a dump.
    dump_start = 1'b1;
    commit();
    dump_start = 1'b0;
    repeat (10) commit();
    #1;
    chk("mid_addr10", 32'(dump_addr), 32'd10);
    rst = 1'b0;
    model_reset();
    #1;
    chk("abort_busy", 32'(dump_busy), 32'd0);
    chk("abort_valid", 32'(dump_valid), 32'd0);
    chk("abort_done", 32'(dump_done), 32'd0);
    chk("abort_addr", 32'(dump_addr), 32'd0);
    chk("abort_data", dump_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("idle_valid", 32'(dump_valid), 32'd0);
      chk("idle_busy", 32'(dump_busy), 32'd0);
      commit();
    end
    dump_start = 1'b1;
    commit();
    dump_start = 1'b0;
    #1;
    chk("restart_addr0", 32'(dump_addr), 32'd0);
    chk("restart_valid", 32'(dump_valid), 32'd1);
    chk("restart_data0", dump_data, 32'd0);
    commit();
    #1;
    chk("restart_addr1", 32'(dump_addr), 32'd1);
    chk("restart_data1", dump_data, 32'd1);
    chk("nb_dump_idle", {nb_busy, nb_valid, nb_done, nb_addr, nb_data[23:0]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
